cam_write_demux_bank: RTL and testbench
=======================================

Name: cam_write_demux_bank

Overview:
- Write-side counterpart of the CAM validation read path: accepts one 32-bit word plus a 5-bit index and steers it into one of 32 registered entries.
- The entry data array and per-entry valid bits are exposed in full for the downstream read mux.
- Supports single-entry invalidate and a sequenced clear-all that sweeps one entry per cycle.

Parameters:
- WIDTH, 32, bits per entry
- DEPTH, 32, number of entries; must be a power of two
- IDX_W, 5, index width; must equal log2(DEPTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wr_valid_i  input  1  write request
- wr_ready_o  output  1  write can be accepted this cycle
- wr_index_i  input  IDX_W  target entry
- wr_data_i  input  WIDTH  write data
- inv_valid_i  input  1  invalidate request, single cycle, no handshake
- inv_index_i  input  IDX_W  entry to invalidate
- clear_i  input  1  start clear-all sweep
- data_o  output  DEPTH*WIDTH  packed entries; entry k occupies bits [k*WIDTH +: WIDTH]
- valid_o  output  DEPTH  per-entry valid
- wr_ack_o  output  1  one-cycle pulse after an accepted write
- ack_index_o  output  IDX_W  index of the acknowledged write
- busy_o  output  1  clear sweep in progress
- full_o  output  1  all valid bits set
- count_o  output  IDX_W+1  number of set valid bits

Behaviour:
- Reset (rst_n=0, async) forces:
  - all data_o and valid_o to 0
  - state to IDLE; clear pointer to 0
  - wr_ack_o=0, ack_index_o=0, busy_o=0, full_o=0, count_o=0
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_i=1.
  - CLEAR -> IDLE after entry DEPTH-1 has been cleared.
  - clear_i is ignored while in CLEAR; the sweep is not restarted.
- wr_ready_o = (state==IDLE) && !clear_i (combinational). Clear has priority over a write in the same cycle.
- Write accept:
  - Occurs on the edge where wr_valid_i && wr_ready_o.
  - Sets data[wr_index_i] <= wr_data_i and valid[wr_index_i] <= 1. Only that entry changes (one-hot decode of the index).
  - A write to an already-valid entry overwrites it; this is not an error.
- Write ack:
  - wr_ack_o=1 and ack_index_o=index in the cycle after acceptance, i.e. the same cycle data_o reflects the write.
  - Back-to-back accepts give back-to-back acks.
- Invalidate:
  - In IDLE, inv_valid_i clears valid[inv_index_i] on the next edge; data is retained.
  - Ignored in CLEAR, and ignored in the cycle clear_i is sampled in IDLE.
- Write and invalidate in the same cycle:
  - Same index: the write wins, so the entry is valid with the new data.
  - Different indices: both take effect.
- CLEAR sweep:
  - Clear pointer starts at 0; each cycle it zeroes data[ptr] and valid[ptr], then increments.
  - The sweep lasts exactly DEPTH cycles. busy_o=1 for all of them.
  - IDLE is re-entered on the edge that clears entry DEPTH-1; busy_o=0 and wr_ready_o=1 in the following cycle.
  - Entries not yet reached keep their old contents during the sweep.
- Flags:
  - full_o = AND of valid_o.
  - count_o = population count of valid_o.
  - Both are combinational from registered valid bits, so they have zero extra latency after the valid update.
- Reset asserted mid-sweep: state returns to IDLE and all entries zero immediately (async), with no residual busy.
- Out-of-range indices cannot occur because DEPTH = 2^IDX_W.

Test Plan:
- Reset with random wr_* inputs active -> all outputs 0, wr_ready_o=1 after release; no entry written while rst_n=0.
- Write idx 5 = 0xDEADBEEF -> next cycle data_o[5*32+:32]=0xDEADBEEF, valid_o=0x00000020, wr_ack_o=1, ack_index_o=5, count_o=1; all other entries unchanged.
- Write idx 0..31 back-to-back (data=0xA5000000|idx), one per cycle -> 32 consecutive acks, full_o=1 and count_o=32 after the last; then invalidate idx 31 -> valid_o=0x7FFFFFFF, data retained, full_o=0.
- Same cycle: write idx 7 = 0x12345678 and invalidate idx 7 -> valid_o[7]=1 with the new data. Repeat with invalidate idx 8 (previously valid) -> valid_o[7]=1, valid_o[8]=0.
- Full bank, pulse clear_i -> busy_o=1 for exactly 32 cycles; entry k reads 0 starting k+1 cycles after the clear edge; wr_valid_i held high with idx 3 stalls (wr_ready_o=0) and is accepted in the first IDLE cycle; final valid_o=0x00000008.
- Assert rst_n=0 at sweep cycle 10 -> busy_o=0 and all entries 0 immediately; after release, a write to idx 1 is accepted in the first cycle.

Source files
------------

// File: rtl/cam_write_demux_bank.sv
// cam_write_demux_bank
//   Write side of the CAM: steers one WIDTH-bit word to one of DEPTH
//   registered entries. It also supports a single-entry invalidate and a
//   clear-all sweep that zeroes one entry per cycle.
// Ports
//   clk, rst_n            clock, async active-low reset
//   wr_valid_i/ready_o    write handshake; wr_index_i / wr_data_i payload
//   inv_valid_i/index_i   single-cycle invalidate, no handshake
//   clear_i               starts the clear-all sweep (ignored while busy)
//   data_o, valid_o       full entry array and valid bits for the read mux
//   wr_ack_o/ack_index_o  pulse one cycle after an accepted write
//   busy_o                sweep in progress
//   full_o, count_o       AND / popcount of valid_o

// One entry. Sweep clear outranks write, and write outranks invalidate.
module cam_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             inv,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (we) begin
            data  <= wdata;
            valid <= 1'b1;
        end else if (inv) begin
            valid <= 1'b0;
        end
    end
endmodule

module cam_write_demux_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [IDX_W-1:0]       wr_index_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   inv_valid_i,
    input  logic [IDX_W-1:0]       inv_index_i,
    input  logic                   clear_i,
    output logic [DEPTH*WIDTH-1:0] data_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic                   wr_ack_o,
    output logic [IDX_W-1:0]       ack_index_o,
    output logic                   busy_o,
    output logic                   full_o,
    output logic [IDX_W:0]         count_o
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              ptr;
    logic                          ptr_last;
    logic                          wr_acc, inv_acc, sweep;
    logic [DEPTH-1:0]              we_vec, inv_vec, clr_vec;
    logic [DEPTH-1:0][WIDTH-1:0]   ent_data;

    assign ptr_last = (ptr == IDX_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: clear_i is only looked at in IDLE, so the sweep cannot restart
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_i)  state_nxt = CLEAR;
            CLEAR:   if (ptr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs from state. clear_i blocks same-cycle writes and invalidates.
    always_comb begin
        wr_ready_o = (state == IDLE) && !clear_i;
        busy_o     = (state == CLEAR);
        sweep      = (state == CLEAR);
    end

    assign wr_acc  = wr_valid_i && wr_ready_o;
    assign inv_acc = inv_valid_i && (state == IDLE) && !clear_i;

    // The pointer wraps to 0 on the last sweep edge, so it is ready for the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr <= '0;
        else if (sweep) ptr <= ptr + 1'b1;
    end

    // One-hot decodes
    always_comb begin
        we_vec  = '0;
        inv_vec = '0;
        clr_vec = '0;
        we_vec[wr_index_i]   = wr_acc;
        inv_vec[inv_index_i] = inv_acc;
        clr_vec[ptr]         = sweep;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        cam_entry #(.WIDTH(WIDTH)) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we_vec[k]),
            .inv   (inv_vec[k]),
            .clr   (clr_vec[k]),
            .wdata (wr_data_i),
            .data  (ent_data[k]),
            .valid (valid_o[k])
        );
    end

    assign data_o = ent_data;

    // The ack lines up with the cycle in which data_o first shows the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_o    <= 1'b0;
            ack_index_o <= '0;
        end else begin
            wr_ack_o <= wr_acc;
            if (wr_acc) ack_index_o <= wr_index_i;
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) count_o = count_o + (IDX_W+1)'(valid_o[i]);
    end

    assign full_o = &valid_o;
endmodule

// File: tb/tb_cam_write_demux_bank.sv
module tb_cam_write_demux_bank;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_valid_i = 1'b0;
    logic                   wr_ready_o;
    logic [IDX_W-1:0]       wr_index_i = '0;
    logic [WIDTH-1:0]       wr_data_i = '0;
    logic                   inv_valid_i = 1'b0;
    logic [IDX_W-1:0]       inv_index_i = '0;
    logic                   clear_i = 1'b0;
    logic [DEPTH*WIDTH-1:0] data_o;
    logic [DEPTH-1:0]       valid_o;
    logic                   wr_ack_o;
    logic [IDX_W-1:0]       ack_index_o;
    logic                   busy_o;
    logic                   full_o;
    logic [IDX_W:0]         count_o;

    cam_write_demux_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_index_i(wr_index_i), .wr_data_i(wr_data_i),
        .inv_valid_i(inv_valid_i), .inv_index_i(inv_index_i),
        .clear_i(clear_i),
        .data_o(data_o), .valid_o(valid_o),
        .wr_ack_o(wr_ack_o), .ack_index_o(ack_index_o),
        .busy_o(busy_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an array of entries plus the number of sweep cycles left
    logic [WIDTH-1:0] m_data [DEPTH];
    bit               m_valid[DEPTH];
    int               m_left;
    bit               m_ack;
    int               m_ack_idx;

    task automatic chk(input string tag, input logic [DEPTH*WIDTH-1:0] obs, input logic [DEPTH*WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_left == 0) && !clear_i;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_valid[i] = 0; end
        m_left = 0; m_ack = 0; m_ack_idx = 0;
    endtask

    // Applies the inputs present at a clock edge
    task automatic m_edge();
        bit rdy;
        rdy   = m_ready();
        m_ack = wr_valid_i && rdy;
        if (m_ack) m_ack_idx = int'(wr_index_i);
        if (m_left > 0) begin
            m_data[DEPTH - m_left] = '0;
            m_valid[DEPTH - m_left] = 0;
            m_left--;
        end else if (clear_i) begin
            m_left = DEPTH;
        end else begin
            if (inv_valid_i) m_valid[inv_index_i] = 0;
            if (wr_valid_i) begin
                m_data[wr_index_i]  = wr_data_i;
                m_valid[wr_index_i] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [DEPTH*WIDTH-1:0] ed;
        logic [DEPTH-1:0]       ev;
        int                     n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ed[i*WIDTH +: WIDTH] = m_data[i];
            ev[i] = m_valid[i];
            n += int'(m_valid[i]);
        end
        chk({tag, ".data"},  data_o, ed);
        chk({tag, ".valid"}, {992'b0, valid_o}, {992'b0, ev});
        chk({tag, ".busy"},  {1023'b0, busy_o}, {1023'b0, m_left > 0});
        chk({tag, ".full"},  {1023'b0, full_o}, {1023'b0, n == DEPTH});
        chk({tag, ".count"}, {1018'b0, count_o}, 1024'(n));
        chk({tag, ".ack"},   {1023'b0, wr_ack_o}, {1023'b0, m_ack});
        if (m_ack) chk({tag, ".ack_idx"}, {1019'b0, ack_index_o}, 1024'(m_ack_idx));
    endtask

    // Inputs are set at posedge+1; readiness is checked before the edge and state after it
    task automatic step(input string tag);
        #2;
        chk({tag, ".ready"}, {1023'b0, wr_ready_o}, {1023'b0, m_ready()});
        @(posedge clk);
        m_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_in();
        wr_valid_i = 0; inv_valid_i = 0; clear_i = 0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        wr_valid_i = 1; wr_index_i = IDX_W'(idx); wr_data_i = d;
    endtask

    initial begin
        int bc;
        bit got;
        m_reset();

        // Reset held with random inputs: nothing may be written
        for (int c = 0; c < 4; c++) begin
            wr_valid_i = 1; wr_index_i = IDX_W'($urandom); wr_data_i = $urandom;
            inv_valid_i = 1'($urandom); inv_index_i = IDX_W'($urandom);
            @(posedge clk); #1;
            check_all("rst");
        end
        idle_in();
        rst_n = 1;
        #1 chk("rst.ready_after", {1023'b0, wr_ready_o}, 1024'd1);

        // Single write
        wr(5, 32'hDEADBEEF);
        step("wr5");
        chk("wr5.slice", {992'b0, data_o[5*32 +: 32]}, 1024'h DEADBEEF);
        chk("wr5.vmask", {992'b0, valid_o}, 1024'h20);
        idle_in();

        // Fill the bank back-to-back
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, 32'hA5000000 | i);
            step($sformatf("fill%0d", i));
        end
        idle_in();
        chk("fill.full",  {1023'b0, full_o}, 1024'd1);
        chk("fill.count", {1018'b0, count_o}, 1024'd32);
        inv_valid_i = 1; inv_index_i = 31;
        step("inv31");
        idle_in();
        chk("inv31.vmask", {992'b0, valid_o}, 1024'h7FFFFFFF);
        chk("inv31.data",  {992'b0, data_o[31*32 +: 32]}, 1024'hA500001F);

        // Write and invalidate in the same cycle
        wr(7, 32'h12345678); inv_valid_i = 1; inv_index_i = 7;
        step("wrinv_same");
        chk("wrinv_same.v7", {1023'b0, valid_o[7]}, 1024'd1);
        wr(7, 32'h12345678); inv_valid_i = 1; inv_index_i = 8;
        step("wrinv_diff");
        chk("wrinv_diff.v78", {1022'b0, valid_o[8:7]}, 1024'b01);
        idle_in();

        // Refill to full, then clear while a write to idx 3 waits
        wr(8, 32'h88888888); step("refill8");
        wr(31, 32'h31313131); step("refill31");
        idle_in();
        chk("preclear.full", {1023'b0, full_o}, 1024'd1);
        clear_i = 1; wr(3, 32'h33333333);
        step("clr0");
        bc = int'(busy_o);
        clear_i = 0;
        got = 0;
        for (int i = 1; i < 40 && !got; i++) begin
            clear_i = (i == 5);
            step($sformatf("sweep%0d", i));
            bc += int'(busy_o);
            got = wr_ack_o;
        end
        idle_in();
        chk("sweep.acked", {1023'b0, got}, 1024'd1);
        chk("sweep.busy_cycles", 1024'(bc), 1024'd32);
        chk("sweep.vmask", {992'b0, valid_o}, 1024'h8);

        // Reset in the middle of a sweep
        for (int i = 0; i < 6; i++) begin wr($urandom_range(0, 31), $urandom); step("prefill"); end
        idle_in();
        clear_i = 1; step("clr1");
        clear_i = 0;
        for (int i = 0; i < 10; i++) step("sweepB");
        #2 rst_n = 0;
        #1 m_reset();
        check_all("midrst");
        chk("midrst.busy", {1023'b0, busy_o}, 1024'd0);
        #2 rst_n = 1;
        wr(1, 32'h01010101);
        step("post_rst_wr1");
        chk("post_rst.ack", {1023'b0, wr_ack_o}, 1024'd1);
        idle_in();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            wr_valid_i  = 1'($urandom_range(0, 3) != 0);
            wr_index_i  = IDX_W'($urandom);
            wr_data_i   = $urandom;
            inv_valid_i = 1'($urandom_range(0, 2) == 0);
            inv_index_i = IDX_W'($urandom);
            clear_i     = ($urandom_range(0, 60) == 0);
            step("rand");
        end
        idle_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
